// File: rtl/tape_pkg.sv
// tape_pkg: shared symbol, port and arbiter state encodings for the tape subsystem
package tape_pkg;
  localparam logic [1:0] SYM_BLANK = 2'b00;
  localparam logic [1:0] SYM_ZERO = 2'b01;
  localparam logic [1:0] SYM_ONE = 2'b10;
  localparam logic [1:0] SYM_HASH = 2'b11;
  localparam logic [1:0] PORT_EDIT = 2'd0;
  localparam logic [1:0] PORT_ENGINE = 2'd1;
  localparam logic [1:0] PORT_LCD = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RWAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/tape_rr_pick.sv
// tape_rr_pick: picks the first requester after last, wrapping mod 3, with last itself checked final
module tape_rr_pick (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] sel
);
  logic [1:0] p1, p2;
  always_comb begin
    p1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    sel = req[p1] ? p1 : req[p2] ? p2 : last;
    valid = |req;
  end
endmodule

// File: rtl/tape_mem_arbiter.sv
// tape_mem_arbiter: round-robin req/ack arbiter sharing the single-port tape RAM between editor, engine and LCD
module tape_mem_arbiter
  import tape_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW = 10,
  parameter int DW = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   rw,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);
  logic [1:0] state, cnt, sel;
  logic valid;
  tape_rr_pick u_pick (.req(req), .last(grant_id), .valid(valid), .sel(sel));
  assign busy = state != ST_IDLE;
  assign ack = (state == ST_DONE) ? NREQ'(1) << grant_id : '0;
  // the ram_* registers double as the transaction latches, so requester changes after the grant are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      rdata <= SYM_BLANK;
      grant_id <= PORT_LCD;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (valid) begin
          state <= ST_ISSUE;
          grant_id <= sel;
          ram_en <= 1'b1;
          ram_we <= ~rw[sel];
          ram_addr <= addr[sel*AW +: AW];
          ram_wdata <= wdata[sel*DW +: DW];
        end
        ST_ISSUE: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          cnt <= 2'(RD_LATENCY);
          state <= ram_we ? ST_DONE : ST_RWAIT;
          if (ram_we) rdata <= SYM_BLANK;
        end
        ST_RWAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            rdata <= ram_rdata;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tape_mem_arbiter.sv
// tb_tape_mem_arbiter: directed and randomized checks of the tape RAM arbiter against a transaction-level model
module tb_tape_mem_arbiter;
  import tape_pkg::*;
  localparam int LAT = 1;
  localparam int AW = 10;
  localparam int DW = 2;
  localparam int N = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] rw = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0] ack;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic busy, ram_en, ram_we;
  logic [1:0] grant_id;
  logic [AW-1:0] ram_addr;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  logic [1:0] mem_tb [1024];
  logic [1:0] m_mem [1024];
  logic [1:0] pipe [LAT];
  logic e_en [N];
  logic e_we [N];
  logic e_busy [N];
  logic [AW-1:0] e_addr [N];
  logic [1:0] e_wd [N];
  logic [1:0] e_rd [N];
  logic [1:0] e_gid [N];
  logic [2:0] e_ack [N];
  int m_free = 0;
  int m_last = 2;

  always #5 clk = ~clk;

  tape_mem_arbiter #(.NREQ(3), .AW(AW), .DW(DW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM environment: junk on the read bus except exactly LAT cycles after a read strobe
  assign ram_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (ram_en && !ram_we) ? mem_tb[ram_addr] : 2'($urandom);
    if (ram_en && ram_we) mem_tb[ram_addr] = ram_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // transaction-level model: a grant at cycle c schedules strobe at c+1 and ack at c+2 (+LAT for reads)
  task automatic model_step(input int c);
    int p, ackc;
    logic rd;
    logic [AW-1:0] a;
    if (rst) begin
      for (int k = c+1; k < N; k++) begin
        e_en[k] = 1'b0; e_busy[k] = 1'b0; e_ack[k] = '0; e_gid[k] = PORT_LCD;
      end
      m_last = 2;
      m_free = c+1;
    end else if (c >= m_free && req != 3'b000) begin
      p = -1;
      for (int k = 1; k <= 3; k++) if (p < 0 && req[(m_last+k)%3]) p = (m_last+k)%3;
      rd = rw[p];
      a = addr[p*AW +: AW];
      ackc = c + 2 + (rd ? LAT : 0);
      e_en[c+1] = 1'b1;
      e_we[c+1] = !rd;
      e_addr[c+1] = a;
      e_wd[c+1] = wdata[p*DW +: DW];
      for (int k = c+1; k <= ackc; k++) e_busy[k] = 1'b1;
      e_ack[ackc] = 3'(1 << p);
      e_rd[ackc] = rd ? m_mem[a] : SYM_BLANK;
      if (!rd) m_mem[a] = wdata[p*DW +: DW];
      for (int k = c+1; k < N; k++) e_gid[k] = 2'(p);
      m_last = p;
      m_free = ackc + 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(cyc);
    cyc++;
  end

  always @(negedge clk) if (chk_on) begin
    chk("ack", 32'(ack), 32'(e_ack[cyc]));
    chk("busy", 32'(busy), 32'(e_busy[cyc]));
    chk("grant_id", 32'(grant_id), 32'(e_gid[cyc]));
    chk("ram_en", 32'(ram_en), 32'(e_en[cyc]));
    if (e_en[cyc]) begin
      chk("ram_we", 32'(ram_we), 32'(e_we[cyc]));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr[cyc]));
      if (e_we[cyc]) chk("ram_wdata", 32'(ram_wdata), 32'(e_wd[cyc]));
    end
    if (e_ack[cyc] != 3'b000) chk("rdata", 32'(rdata), 32'(e_rd[cyc]));
  end

  task automatic new_payload(input int i);
    rw[i] = 1'($urandom);
    addr[i*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
    wdata[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    int seq [6] = '{1, 2, 0, 1, 2, 0};
    int re [3];
    int got, n_en, n_ack;
    logic [2:0] pend;
    for (int i = 0; i < 1024; i++) mem_tb[i] = 2'($urandom);
    mem_tb[5] = SYM_ONE;
    for (int i = 0; i < 1024; i++) m_mem[i] = mem_tb[i];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_gid", 32'(grant_id), 32'd2);
    chk("reset_ram_en", 32'(ram_en), 32'd0);
    // single read by the LCD port
    req = 3'b100; rw = 3'b100; addr[2*AW +: AW] = 10'h005;
    @(negedge clk);
    chk("rd_strobe", 32'(ram_en), 32'd1);
    chk("rd_strobe_addr", 32'(ram_addr), 32'h005);
    repeat (LAT+1) @(negedge clk);
    chk("rd_ack", 32'(ack), 32'b100);
    chk("rd_data", 32'(rdata), 32'(SYM_ONE));
    req = 3'b000;
    @(negedge clk);
    chk("rd_idle", 32'(busy), 32'd0);
    // engine writes '#' to the top address, editor reads it back
    req = 3'b010; rw = 3'b000; addr[AW +: AW] = 10'h3FF; wdata[DW +: DW] = SYM_HASH;
    repeat (2) @(negedge clk);
    chk("wr_ack", 32'(ack), 32'b010);
    req = 3'b000;
    @(negedge clk);
    req = 3'b001; rw = 3'b001; addr[0 +: AW] = 10'h3FF;
    repeat (2+LAT) @(negedge clk);
    chk("rb_ack", 32'(ack), 32'b001);
    chk("rb_data", 32'(rdata), 32'(SYM_HASH));
    req = 3'b000;
    @(negedge clk);
    // contention: last grant was port 0, so order continues 1,2,0,...
    rw = 3'b111; req = 3'b111; re = '{0, 0, 0}; got = 0;
    for (int k = 0; k < 80 && got < 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (re[i] > 0) begin
        re[i]--;
        if (re[i] == 0) req[i] = 1'b1;
      end
      for (int i = 0; i < 3; i++) if (ack[i] && got < 6) begin
        chk("rr_order", 32'(i), 32'(seq[got]));
        got++;
        req[i] = 1'b0;
        re[i] = 2;
      end
    end
    req = 3'b000;
    chk("rr_count", 32'(got), 32'd6);
    @(negedge clk);
    // early drop: one-cycle request still completes exactly once
    req = 3'b001; rw = 3'b000; addr[0 +: AW] = 10'h007; wdata[0 +: DW] = SYM_ZERO;
    n_en = 0; n_ack = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_en += int'(ram_en);
      n_ack += int'(ack[0]);
      req = 3'b000;
    end
    chk("early_ack_count", 32'(n_ack), 32'd1);
    chk("early_en_count", 32'(n_en), 32'd1);
    // reset during the read wait aborts the read and restores port 0 priority
    req = 3'b010; rw = 3'b010; addr[AW +: AW] = 10'h005;
    repeat (2) @(negedge clk);
    rst = 1'b1; req = 3'b000;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_gid", 32'(grant_id), 32'd2);
    rst = 1'b0;
    req = 3'b011; rw = 3'b011; addr[0 +: AW] = 10'h3FF;
    n_ack = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        if (n_ack == 0) chk("after_rst_first", 32'(ack), 32'b001);
        n_ack++;
        req = req & ~ack;
      end
    end
    chk("after_rst_acks", 32'(n_ack), 32'd2);
    // randomized traffic with occasional resets, checked cycle by cycle against the model
    pend = '0;
    repeat (2500) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) begin
          pend[i] = ($urandom_range(0, 7) == 0);
          req[i] = pend[i];
          if (pend[i]) new_payload(i);
        end else if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[i] = 1'b1;
            req[i] = 1'b1;
            new_payload(i);
          end
        end else if ($urandom_range(0, 24) == 0) begin
          pend[i] = 1'b0;
          req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) new_payload(i);
      end
    end
    rst = 1'b0;
    req = 3'b000;
    repeat (10) @(negedge clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
